// File: rtl/khazad_cbc_ctrl.sv
// ---------------------------------------------------------------------------
// khazad_cbc_ctrl
//
// Cipher-block-chaining controller that sits in front of a 64-bit block
// cipher core (KHAZAD-style: 64-bit block, 128-bit key). The controller
// accepts one block at a time from the host, applies the CBC pre-whitening
// (encrypt) or post-whitening (decrypt) against the chain register, starts
// the core, waits for the core to signal its last round, captures the
// result and offers it to the consumer with a valid/ready handshake.
//
// Ports
//   CLK             rising-edge clock
//   RST             synchronous active-high reset
//   key_in[127:0]   cipher key, stable for a whole chain
//   iv_in[63:0]     initialisation vector
//   iv_load         load iv_in into the chain register (IDLE only)
//   enc_mode        1 = CBC encrypt, 0 = CBC decrypt, latched per block
//   in_valid        host block valid
//   in_ready        controller accepts a block
//   in_data[63:0]   plaintext (encrypt) or ciphertext (decrypt)
//   out_valid       result valid
//   out_ready       consumer accepts the result
//   out_data[63:0]  CBC result
//   blk_cnt[31:0]   blocks completed since the last iv_load
//   core_*          interface to the block cipher core
// ---------------------------------------------------------------------------
module khazad_cbc_ctrl (
  input  logic          CLK,
  input  logic          RST,
  input  logic [127:0]  key_in,
  input  logic [63:0]   iv_in,
  input  logic          iv_load,
  input  logic          enc_mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_data,
  output logic [31:0]   blk_cnt,
  output logic [63:0]   core_data_in,
  output logic [127:0]  core_key,
  output logic          core_enc,
  output logic          core_start,
  output logic          core_only_data,
  input  logic [63:0]   core_data_out,
  input  logic          core_last_round
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] CAPT  = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [63:0] chain_q, chain_d;
  logic [63:0] blk_q, blk_d;
  logic        mode_q, mode_d;
  logic        first_q, first_d;
  logic [63:0] out_data_q, out_data_d;
  logic [31:0] blk_cnt_q, blk_cnt_d;
  logic [63:0] core_din_q, core_din_d;

  // Next-state and datapath. The core input word is computed once at accept
  // time and registered, so it stays constant while the core is running even
  // though the chain register may be rewritten in CAPT.
  always_comb begin
    state_d    = state_q;
    chain_d    = chain_q;
    blk_d      = blk_q;
    mode_d     = mode_q;
    first_d    = first_q;
    out_data_d = out_data_q;
    blk_cnt_d  = blk_cnt_q;
    core_din_d = core_din_q;

    case (state_q)
      IDLE: begin
        // A new IV always wins over a pending data block.
        if (iv_load) begin
          chain_d   = iv_in;
          blk_cnt_d = 32'd0;
          first_d   = 1'b1;
        end else if (in_valid) begin
          blk_d      = in_data;
          mode_d     = enc_mode;
          core_din_d = enc_mode ? (in_data ^ chain_q) : in_data;
          state_d    = START;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (core_last_round) state_d = CAPT;
      end
      CAPT: begin
        // Encrypt chains on the ciphertext just produced; decrypt chains on
        // the ciphertext that was fed in.
        if (mode_q) begin
          out_data_d = core_data_out;
          chain_d    = core_data_out;
        end else begin
          out_data_d = core_data_out ^ chain_q;
          chain_d    = blk_q;
        end
        first_d   = 1'b0;
        blk_cnt_d = blk_cnt_q + 32'd1;
        state_d   = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      chain_q    <= 64'd0;
      blk_q      <= 64'd0;
      mode_q     <= 1'b1;
      first_q    <= 1'b1;
      out_data_q <= 64'd0;
      blk_cnt_q  <= 32'd0;
      core_din_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      chain_q    <= chain_d;
      blk_q      <= blk_d;
      mode_q     <= mode_d;
      first_q    <= first_d;
      out_data_q <= out_data_d;
      blk_cnt_q  <= blk_cnt_d;
      core_din_q <= core_din_d;
    end
  end

  // Handshake strobes are gated by RST so they are quiet during reset even
  // before the state register has been cleared.
  assign in_ready       = (state_q == IDLE) && !iv_load && !RST;
  assign out_valid      = (state_q == OUT) && !RST;
  assign core_start     = (state_q == START) && !RST;
  assign out_data       = out_data_q;
  assign blk_cnt        = blk_cnt_q;
  assign core_data_in   = core_din_q;
  assign core_key       = key_in;
  assign core_enc       = mode_q;
  // The core only needs a fresh key schedule for the first block of a chain.
  assign core_only_data = !first_q;

endmodule

// File: tb/tb_khazad_cbc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_khazad_cbc_ctrl
//
// Directed bench for khazad_cbc_ctrl. A toy invertible cipher stands in for
// the real core: encrypt is rotate-left-8 then XOR with a folded key, with a
// fixed three-cycle RUN phase. Stimulus pushes expected core transactions and
// expected results into queues; a monitor pops and compares them whenever
// the DUT starts the core or completes an output handshake.
// ---------------------------------------------------------------------------
module tb_khazad_cbc_ctrl;

  localparam logic [127:0] KEY = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

  logic          CLK = 1'b0;
  logic          RST;
  logic [127:0]  key_in;
  logic [63:0]   iv_in;
  logic          iv_load;
  logic          enc_mode;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic [31:0]   blk_cnt;
  logic [63:0]   core_data_in;
  logic [127:0]  core_key;
  logic          core_enc;
  logic          core_start;
  logic          core_only_data;
  logic [63:0]   core_data_out;
  logic          core_last_round;

  typedef struct packed {
    logic [63:0] din;
    logic        enc;
    logic        only;
  } core_exp_t;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] cnt;
  } out_exp_t;

  core_exp_t core_q[$];
  out_exp_t  out_q[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] m_chain;
  logic        m_first;
  logic [31:0] m_cnt;
  logic [63:0] last_exp;

  logic [63:0] core_res = 64'd0;
  logic [3:0]  core_cnt = 4'd0;

  khazad_cbc_ctrl dut (
    .CLK             (CLK),
    .RST             (RST),
    .key_in          (key_in),
    .iv_in           (iv_in),
    .iv_load         (iv_load),
    .enc_mode        (enc_mode),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .blk_cnt         (blk_cnt),
    .core_data_in    (core_data_in),
    .core_key        (core_key),
    .core_enc        (core_enc),
    .core_start      (core_start),
    .core_only_data  (core_only_data),
    .core_data_out   (core_data_out),
    .core_last_round (core_last_round)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] toy_enc(input logic [63:0] x, input logic [127:0] k);
    logic [63:0] kk;
    kk = k[127:64] ^ k[63:0];
    return {x[55:0], x[63:56]} ^ kk;
  endfunction

  function automatic logic [63:0] toy_dec(input logic [63:0] y, input logic [127:0] k);
    logic [63:0] t;
    t = y ^ k[127:64] ^ k[63:0];
    return {t[7:0], t[63:8]};
  endfunction

  // Stand-in cipher core: result is ready at start, last_round pulses on the
  // third RUN cycle.
  always @(posedge CLK) begin
    if (core_start) begin
      core_res <= core_enc ? toy_enc(core_data_in, core_key) : toy_dec(core_data_in, core_key);
      core_cnt <= 4'd3;
    end else if (core_cnt != 4'd0) begin
      core_cnt <= core_cnt - 4'd1;
    end
  end
  assign core_data_out   = core_res;
  assign core_last_round = (core_cnt == 4'd1);

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: core starts and output handshakes are checked against the queues.
  always @(negedge CLK) begin
    if (core_start) begin
      if (core_q.size() == 0) begin
        checkOutput("unexpected_core_start", 128'd1, 128'd0);
      end else begin
        core_exp_t ce;
        ce = core_q.pop_front();
        checkOutput("core_data_in", {64'd0, core_data_in}, {64'd0, ce.din});
        checkOutput("core_enc", {127'd0, core_enc}, {127'd0, ce.enc});
        checkOutput("core_only_data", {127'd0, core_only_data}, {127'd0, ce.only});
        checkOutput("core_key", core_key, KEY);
      end
    end
    if (out_valid && out_ready) begin
      if (out_q.size() == 0) begin
        checkOutput("unexpected_out_valid", 128'd1, 128'd0);
      end else begin
        out_exp_t oe;
        oe = out_q.pop_front();
        checkOutput("out_data", {64'd0, out_data}, {64'd0, oe.data});
        checkOutput("blk_cnt_at_out", {96'd0, blk_cnt}, {96'd0, oe.cnt});
      end
    end
  end

  task automatic waitInReady(input int limit);
    int n = 0;
    while (!in_ready && n < limit) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 128'd0, 128'd1);
  endtask

  task automatic waitOutValid(input int limit);
    int n = 0;
    while (!out_valid && n < limit) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!out_valid) checkOutput("out_valid_timeout", 128'd0, 128'd1);
  endtask

  task automatic loadIv(input logic [63:0] iv);
    iv_in   = iv;
    iv_load = 1'b1;
    @(posedge CLK); #1;
    iv_load = 1'b0;
    m_chain = iv;
    m_first = 1'b1;
    m_cnt   = 32'd0;
  endtask

  // Issues one block; expected core input and result come from the CBC model
  // unless an explicit hand-computed result is supplied.
  task automatic applyStimulus(input logic [63:0] data, input logic mode,
                               input logic use_exp, input logic [63:0] exp_data);
    logic [63:0] din;
    logic [63:0] res;
    core_exp_t   ce;
    out_exp_t    oe;
    din = mode ? (data ^ m_chain) : data;
    res = mode ? toy_enc(din, KEY) : (toy_dec(data, KEY) ^ m_chain);
    ce.din  = din;
    ce.enc  = mode;
    ce.only = !m_first;
    core_q.push_back(ce);
    m_chain  = mode ? res : data;
    m_first  = 1'b0;
    m_cnt    = m_cnt + 32'd1;
    last_exp = res;
    oe.data  = use_exp ? exp_data : res;
    oe.cnt   = m_cnt;
    out_q.push_back(oe);
    waitInReady(20);
    in_data  = data;
    enc_mode = mode;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] pt [3];
    logic [63:0] ct [3];
    logic [63:0] exp_hold;
    logic        saw_valid;

    pt[0] = 64'h0011223344556677;
    pt[1] = 64'h8899AABBCCDDEEFF;
    pt[2] = 64'hA5A5A5A55A5A5A5A;

    RST = 1'b1; key_in = KEY; iv_in = 64'd0; iv_load = 1'b0; enc_mode = 1'b1;
    in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b1;
    m_chain = 64'd0; m_first = 1'b1; m_cnt = 32'd0; last_exp = 64'd0;

    // Reset values
    repeat (3) begin @(posedge CLK); #1; end
    checkOutput("rst_in_ready", {127'd0, in_ready}, 128'd0);
    checkOutput("rst_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("rst_core_start", {127'd0, core_start}, 128'd0);
    checkOutput("rst_blk_cnt", {96'd0, blk_cnt}, 128'd0);
    checkOutput("rst_out_data", {64'd0, out_data}, 128'd0);
    checkOutput("rst_core_enc", {127'd0, core_enc}, 128'd1);
    RST = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", {127'd0, in_ready}, 128'd1);
    checkOutput("post_rst_only_data", {127'd0, core_only_data}, 128'd0);

    // IV = 0, encrypt: core input equals plaintext
    loadIv(64'd0);
    applyStimulus(64'h0123456789ABCDEF, 1'b1, 1'b0, 64'd0);
    checkOutput("s1_core_start", {127'd0, core_start}, 128'd1);
    checkOutput("s1_din", {64'd0, core_data_in}, {64'd0, 64'h0123456789ABCDEF});
    checkOutput("s1_only", {127'd0, core_only_data}, 128'd0);
    waitInReady(20);

    // IV = all ones, encrypt: core input is the complement
    loadIv(64'hFFFFFFFFFFFFFFFF);
    applyStimulus(64'h0123456789ABCDEF, 1'b1, 1'b0, 64'd0);
    checkOutput("s2_din", {64'd0, core_data_in}, {64'd0, 64'hFEDCBA9876543210});
    waitInReady(20);

    // Three-block encrypt then decrypt with the same IV
    loadIv(64'h1122334455667788);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(pt[i], 1'b1, 1'b0, 64'd0);
      ct[i] = last_exp;
      waitInReady(20);
    end
    checkOutput("s3_enc_blk_cnt", {96'd0, blk_cnt}, 128'd3);
    loadIv(64'h1122334455667788);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ct[i], 1'b0, 1'b1, pt[i]);
      waitInReady(20);
    end
    checkOutput("s3_dec_blk_cnt", {96'd0, blk_cnt}, 128'd3);

    // Back-pressure in OUT
    out_ready = 1'b0;
    applyStimulus(64'hCAFEF00DDEADBEEF, 1'b1, 1'b0, 64'd0);
    exp_hold = last_exp;
    waitOutValid(20);
    for (int i = 0; i < 5; i++) begin
      checkOutput("s4_out_valid", {127'd0, out_valid}, 128'd1);
      checkOutput("s4_out_data", {64'd0, out_data}, {64'd0, exp_hold});
      checkOutput("s4_in_ready", {127'd0, in_ready}, 128'd0);
      checkOutput("s4_core_start", {127'd0, core_start}, 128'd0);
      @(posedge CLK); #1;
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    waitInReady(20);

    // Reset during RUN aborts the block
    applyStimulus(64'h0F0F0F0FF0F0F0F0, 1'b1, 1'b0, 64'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    void'(out_q.pop_back());
    m_chain = 64'd0; m_first = 1'b1; m_cnt = 32'd0;
    @(posedge CLK); #1;
    checkOutput("s5_rst_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("s5_rst_in_ready", {127'd0, in_ready}, 128'd0);
    RST = 1'b0;
    #1;
    checkOutput("s5_in_ready", {127'd0, in_ready}, 128'd1);
    checkOutput("s5_blk_cnt", {96'd0, blk_cnt}, 128'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    checkOutput("s5_no_out_valid", {127'd0, saw_valid}, 128'd0);
    applyStimulus(64'h13579BDF2468ACE0, 1'b1, 1'b0, 64'd0);
    checkOutput("s5_only", {127'd0, core_only_data}, 128'd0);
    checkOutput("s5_din", {64'd0, core_data_in}, {64'd0, 64'h13579BDF2468ACE0});
    waitInReady(20);

    // iv_load during RUN is ignored
    applyStimulus(64'h0102030405060708, 1'b1, 1'b0, 64'd0);
    exp_hold = last_exp;
    @(posedge CLK); #1;
    iv_in   = 64'hDEADBEEFDEADBEEF;
    iv_load = 1'b1;
    @(posedge CLK); #1;
    iv_load = 1'b0;
    waitInReady(20);
    checkOutput("s6_blk_cnt", {96'd0, blk_cnt}, 128'd2);
    applyStimulus(64'h1111111122222222, 1'b1, 1'b0, 64'd0);
    checkOutput("s6_din", {64'd0, core_data_in}, {64'd0, 64'h1111111122222222 ^ exp_hold});
    checkOutput("s6_only", {127'd0, core_only_data}, 128'd1);
    waitInReady(20);

    repeat (3) begin @(posedge CLK); #1; end
    checkOutput("core_queue_empty", 128'(core_q.size()), 128'd0);
    checkOutput("out_queue_empty", 128'(out_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
